// File: rtl/cbb_ecc_dec_pipe.sv
// cbb_ecc_dec_pipe: two-stage SECDED (extended Hamming) decoder with valid/ready flow, error counters and first-error log.
// Optional CBB_ECC_DEC_ERR_INJ_EN adds inj_mask, XORed onto the incoming codeword for error injection.
module cbb_ecc_dec_pipe #(
    parameter int DW = 32,
    parameter int EW = 7,
    parameter int TW = 8,
    parameter int CW = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW+EW-1:0] in_data,
    input  logic [TW-1:0]    in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [TW-1:0]    out_tag,
    output logic             out_sec,
    output logic             out_ded,
    output logic [CW-1:0]    sec_cnt,
    output logic [CW-1:0]    ded_cnt,
    input  logic             cnt_clr,
    output logic             log_valid,
    output logic [TW-1:0]    log_tag,
    output logic [EW-2:0]    log_syn,
    output logic             log_ded,
    input  logic             log_clr
`ifdef CBB_ECC_DEC_ERR_INJ_EN
    ,
    input  logic [DW+EW-1:0] inj_mask
`endif
);
    localparam int SW = EW - 1;

    if ((1 << SW) < DW + EW) begin : g_bad_param
        $error("cbb_ecc_dec_pipe: EW=%0d too small for DW=%0d", EW, DW);
    end

    // Hamming position of data bit i: the i-th non-power-of-two position from 3.
    function automatic int dpos(input int i);
        int p;
        int n;
        p = 2;
        n = -1;
        while (n < i) begin
            p++;
            if ((p & (p - 1)) != 0) n++;
        end
        return p;
    endfunction

    logic [SW-1:0] pos [DW];
    for (genvar g = 0; g < DW; g++) begin : g_pos
        localparam int P = dpos(g);
        assign pos[g] = P[SW-1:0];
    end

    logic [DW+EW-1:0] cw;
`ifdef CBB_ECC_DEC_ERR_INJ_EN
    assign cw = in_data ^ inj_mask;
`else
    assign cw = in_data;
`endif

    logic          s1_valid_q, s2_valid_q, s1_par_q, s1_par_d;
    logic [SW-1:0] s1_syn_q, s1_syn_d, s2_syn_q;
    logic [DW-1:0] s1_data_q, s2_data_q, s2_data_d, flip;
    logic [TW-1:0] s1_tag_q, s2_tag_q;
    logic          s2_sec_q, s2_ded_q, s2_sec_d, s2_ded_d;
    logic [CW-1:0] sec_cnt_q, ded_cnt_q, sec_cnt_d, ded_cnt_d;
    logic          log_valid_q, log_valid_d, log_ded_q;
    logic [TW-1:0] log_tag_q;
    logic [SW-1:0] log_syn_q;
    logic          s2_load, in_fire, out_fire, log_cap, nz, pow2;

    assign s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
    assign in_ready = ~s1_valid_q | s2_load;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = s2_valid_q & out_ready;

    always_comb begin
        s1_syn_d = cw[DW+:SW];
        for (int i = 0; i < DW; i++) s1_syn_d = cw[i] ? s1_syn_d ^ pos[i] : s1_syn_d;
        s1_par_d = ^cw;
    end

    // A syndrome equal to no data position and no check position is uncorrectable.
    always_comb begin
        for (int i = 0; i < DW; i++) flip[i] = s1_syn_q == pos[i];
        nz        = |s1_syn_q;
        pow2      = nz & ~|(s1_syn_q & (s1_syn_q - SW'(1)));
        s2_ded_d  = nz & (~s1_par_q | (~|flip & ~pow2));
        s2_sec_d  = s1_par_q & ~s2_ded_d;
        s2_data_d = s2_ded_d ? s1_data_q : s1_data_q ^ flip;
    end

    always_comb begin
        sec_cnt_d   = cnt_clr ? CW'(out_fire & s2_sec_q)
                              : sec_cnt_q + CW'(out_fire & s2_sec_q & ~&sec_cnt_q);
        ded_cnt_d   = cnt_clr ? CW'(out_fire & s2_ded_q)
                              : ded_cnt_q + CW'(out_fire & s2_ded_q & ~&ded_cnt_q);
        log_cap     = out_fire & (s2_sec_q | s2_ded_q) & (~log_valid_q | log_clr);
        log_valid_d = log_cap | (log_valid_q & ~log_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_syn_q    <= '0;
            s1_par_q    <= 1'b0;
            s1_data_q   <= '0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_syn_q    <= '0;
            s2_data_q   <= '0;
            s2_tag_q    <= '0;
            s2_sec_q    <= 1'b0;
            s2_ded_q    <= 1'b0;
            sec_cnt_q   <= '0;
            ded_cnt_q   <= '0;
            log_valid_q <= 1'b0;
            log_tag_q   <= '0;
            log_syn_q   <= '0;
            log_ded_q   <= 1'b0;
        end else begin
            if (in_ready) s1_valid_q <= in_valid;
            if (in_fire) begin
                s1_syn_q  <= s1_syn_d;
                s1_par_q  <= s1_par_d;
                s1_data_q <= cw[DW-1:0];
                s1_tag_q  <= in_tag;
            end
            if (~s2_valid_q | out_ready) s2_valid_q <= s1_valid_q;
            if (s2_load) begin
                s2_syn_q  <= s1_syn_q;
                s2_data_q <= s2_data_d;
                s2_tag_q  <= s1_tag_q;
                s2_sec_q  <= s2_sec_d;
                s2_ded_q  <= s2_ded_d;
            end
            sec_cnt_q   <= sec_cnt_d;
            ded_cnt_q   <= ded_cnt_d;
            log_valid_q <= log_valid_d;
            if (log_cap) begin
                log_tag_q <= s2_tag_q;
                log_syn_q <= s2_syn_q;
                log_ded_q <= s2_ded_q;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_tag   = s2_tag_q;
    assign out_sec   = s2_sec_q;
    assign out_ded   = s2_ded_q;
    assign sec_cnt   = sec_cnt_q;
    assign ded_cnt   = ded_cnt_q;
    assign log_valid = log_valid_q;
    assign log_tag   = log_tag_q;
    assign log_syn   = log_syn_q;
    assign log_ded   = log_ded_q;
endmodule

// File: tb/tb_cbb_ecc_dec_pipe.sv
// tb_cbb_ecc_dec_pipe: directed checks of the SECDED decode pipeline, flow control, counters and log.
// A second instance with CW=2 exercises counter saturation on the same stimulus.
module tb_cbb_ecc_dec_pipe;
    localparam int NW = 39;

    logic          clk = 0, rst_n = 0, in_valid = 0, out_ready = 1, cnt_clr = 0, log_clr = 0;
    logic [NW-1:0] in_data = '0;
    logic [7:0]    in_tag = '0;
    logic          in_ready, out_valid, out_sec, out_ded, log_valid, log_ded;
    logic [31:0]   out_data;
    logic [7:0]    out_tag, log_tag;
    logic [5:0]    log_syn;
    logic [15:0]   sec_cnt, ded_cnt;
    logic          s_in_ready, s_out_valid, s_out_sec, s_out_ded, s_log_valid, s_log_ded;
    logic [31:0]   s_out_data;
    logic [7:0]    s_out_tag, s_log_tag;
    logic [5:0]    s_log_syn;
    logic [1:0]    s_sec_cnt, s_ded_cnt;
`ifdef CBB_ECC_DEC_ERR_INJ_EN
    logic [NW-1:0] inj_mask = '0;
`endif

    int checks = 0, errors = 0;
    logic        r_v, r_s, r_e;
    logic [31:0] r_d;
    logic [7:0]  r_t;

    always #5 clk = ~clk;

    cbb_ecc_dec_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_sec(out_sec), .out_ded(out_ded), .sec_cnt(sec_cnt),
        .ded_cnt(ded_cnt), .cnt_clr(cnt_clr), .log_valid(log_valid), .log_tag(log_tag),
        .log_syn(log_syn), .log_ded(log_ded), .log_clr(log_clr)
`ifdef CBB_ECC_DEC_ERR_INJ_EN
        , .inj_mask(inj_mask)
`endif
    );

    cbb_ecc_dec_pipe #(.CW(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .in_tag(in_tag), .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_tag(s_out_tag), .out_sec(s_out_sec), .out_ded(s_out_ded), .sec_cnt(s_sec_cnt),
        .ded_cnt(s_ded_cnt), .cnt_clr(cnt_clr), .log_valid(s_log_valid), .log_tag(s_log_tag),
        .log_syn(s_log_syn), .log_ded(s_log_ded), .log_clr(log_clr)
`ifdef CBB_ECC_DEC_ERR_INJ_EN
        , .inj_mask(inj_mask)
`endif
    );

    // One word through an idle pipe; result sampled the cycle before its output transfer,
    // where the optional clear pulses are applied.
    task automatic run_word(input logic [NW-1:0] d, input logic [7:0] t, input logic lc, input logic cc);
        @(negedge clk);
        in_valid = 1; in_data = d; in_tag = t;
        @(posedge clk); #1;
        in_valid = 0; in_data = '0;
        @(posedge clk); #1;
        r_v = out_valid; r_d = out_data; r_t = out_tag; r_s = out_sec; r_e = out_ded;
        log_clr = lc; cnt_clr = cc;
        @(posedge clk); #1;
        log_clr = 0; cnt_clr = 0;
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if ({sec_cnt, ded_cnt} !== 32'h0) begin errors++; $display("FAIL reset_cnt got %h/%h want 0/0", sec_cnt, ded_cnt); end
        checks++; if ({log_valid, out_data, out_tag} !== 41'h0) begin errors++; $display("FAIL reset_state got log_valid=%b data=%h tag=%h want 0", log_valid, out_data, out_tag); end
    endtask

    task automatic test_clean;
        run_word(39'h0, 8'h11, 0, 0);
        checks++; if ({r_v, r_d, r_t, r_s, r_e} !== {1'b1, 32'h0, 8'h11, 2'b00}) begin errors++; $display("FAIL clean got v=%b d=%h t=%h sec=%b ded=%b want 1/0/11/0/0", r_v, r_d, r_t, r_s, r_e); end
        checks++; if ({sec_cnt, ded_cnt} !== 32'h0) begin errors++; $display("FAIL clean_cnt got %h/%h want 0/0", sec_cnt, ded_cnt); end
    endtask

    task automatic test_sec_data;
        run_word(39'h20, 8'hA5, 0, 0);
        checks++; if ({r_v, r_d, r_t, r_s, r_e} !== {1'b1, 32'h0, 8'hA5, 2'b10}) begin errors++; $display("FAIL sec_data got v=%b d=%h t=%h sec=%b ded=%b want 1/0/a5/1/0", r_v, r_d, r_t, r_s, r_e); end
        checks++; if (sec_cnt !== 16'd1) begin errors++; $display("FAIL sec_data_cnt got %0d want 1", sec_cnt); end
        checks++; if ({log_valid, log_syn, log_tag, log_ded} !== {1'b1, 6'h0A, 8'hA5, 1'b0}) begin errors++; $display("FAIL sec_data_log got v=%b syn=%h tag=%h ded=%b want 1/0a/a5/0", log_valid, log_syn, log_tag, log_ded); end
    endtask

    task automatic test_parity_double;
        run_word(39'h40_0000_0000, 8'h01, 0, 0);
        checks++; if ({r_d, r_s, r_e} !== {32'h0, 2'b10}) begin errors++; $display("FAIL parity_bit got d=%h sec=%b ded=%b want 0/1/0", r_d, r_s, r_e); end
        run_word(39'h3, 8'h02, 0, 0);
        checks++; if ({r_d, r_s, r_e} !== {32'h3, 2'b01}) begin errors++; $display("FAIL double got d=%h sec=%b ded=%b want 3/0/1", r_d, r_s, r_e); end
        checks++; if ({sec_cnt, ded_cnt} !== {16'd2, 16'd1}) begin errors++; $display("FAIL double_cnt got %0d/%0d want 2/1", sec_cnt, ded_cnt); end
        checks++; if ({log_tag, log_syn, log_ded} !== {8'hA5, 6'h0A, 1'b0}) begin errors++; $display("FAIL log_kept got tag=%h syn=%h ded=%b want a5/0a/0", log_tag, log_syn, log_ded); end
    endtask

    task automatic test_other_syndromes;
        run_word(39'h1_0000_0000, 8'h03, 0, 0);
        checks++; if ({r_d, r_s, r_e} !== {32'h0, 2'b10}) begin errors++; $display("FAIL check_bit got d=%h sec=%b ded=%b want 0/1/0", r_d, r_s, r_e); end
        run_word(39'h43_0000_0000, 8'h04, 0, 0);
        checks++; if ({r_d, r_s, r_e} !== {32'h1, 2'b10}) begin errors++; $display("FAIL flip_bit0 got d=%h sec=%b ded=%b want 1/1/0", r_d, r_s, r_e); end
        run_word(39'h24_0000_0001, 8'h05, 0, 0);
        checks++; if ({r_d, r_s, r_e} !== {32'h1, 2'b01}) begin errors++; $display("FAIL unmapped got d=%h sec=%b ded=%b want 1/0/1", r_d, r_s, r_e); end
        checks++; if ({sec_cnt, ded_cnt} !== {16'd4, 16'd2}) begin errors++; $display("FAIL syn_cnt got %0d/%0d want 4/2", sec_cnt, ded_cnt); end
    endtask

    task automatic test_log;
        @(negedge clk); log_clr = 1;
        @(posedge clk); #1; log_clr = 0;
        checks++; if (log_valid !== 1'b0) begin errors++; $display("FAIL log_clr got %b want 0", log_valid); end
        run_word(39'h3, 8'h33, 0, 0);
        checks++; if ({log_valid, log_tag, log_syn, log_ded} !== {1'b1, 8'h33, 6'h06, 1'b1}) begin errors++; $display("FAIL log_ded got v=%b tag=%h syn=%h ded=%b want 1/33/06/1", log_valid, log_tag, log_syn, log_ded); end
        run_word(39'h20, 8'h44, 1, 0);
        checks++; if ({log_valid, log_tag, log_syn, log_ded} !== {1'b1, 8'h44, 6'h0A, 1'b0}) begin errors++; $display("FAIL log_clr_cap got v=%b tag=%h syn=%h ded=%b want 1/44/0a/0", log_valid, log_tag, log_syn, log_ded); end
        run_word(39'h20, 8'h55, 0, 0);
        checks++; if (log_tag !== 8'h44) begin errors++; $display("FAIL log_no_overwrite got %h want 44", log_tag); end
    endtask

    task automatic test_back_to_back;
        logic [NW-1:0] w [4];
        logic [31:0]   exp_d [4];
        logic [7:0]    got_t [8];
        logic [31:0]   got_d [8];
        int k, n;
        logic rdy, ov;
        w[0] = 39'h0; w[1] = 39'h20; w[2] = 39'h43_0000_0001; w[3] = 39'h3;
        exp_d[0] = 32'h0; exp_d[1] = 32'h0; exp_d[2] = 32'h1; exp_d[3] = 32'h3;
        k = 0; n = 0;
        out_ready = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            in_valid = 1; in_data = w[k]; in_tag = 8'hB0 + 8'(k);
            #1; rdy = in_ready;
            @(posedge clk);
            if (rdy) k++;
        end
        #1;
        checks++; if (k !== 2) begin errors++; $display("FAIL bp_accepted got %0d want 2", k); end
        checks++; if ({in_ready, out_valid, out_tag} !== {1'b0, 1'b1, 8'hB0}) begin errors++; $display("FAIL bp_stall got rdy=%b ov=%b tag=%h want 0/1/b0", in_ready, out_valid, out_tag); end
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            out_ready = 1;
            in_valid = k < 4;
            in_data = k < 4 ? w[k] : '0;
            in_tag = 8'hB0 + 8'(k);
            #1; rdy = in_ready; ov = out_valid;
            if (ov && n < 8) begin got_t[n] = out_tag; got_d[n] = out_data; end
            @(posedge clk);
            if (rdy && k < 4) k++;
            if (ov) n++;
        end
        in_valid = 0;
        checks++; if (n !== 4) begin errors++; $display("FAIL bp_count got %0d want 4", n); end
        for (int i = 0; i < 4; i++) begin
            checks++; if ({got_t[i], got_d[i]} !== {8'hB0 + 8'(i), exp_d[i]}) begin errors++; $display("FAIL bp_word%0d got tag=%h d=%h want %h/%h", i, got_t[i], got_d[i], 8'hB0 + 8'(i), exp_d[i]); end
        end
    endtask

`ifdef CBB_ECC_DEC_ERR_INJ_EN
    task automatic test_inject;
        inj_mask = 39'h1;
        run_word(39'h0, 8'h61, 0, 0);
        checks++; if ({r_d, r_s, r_e} !== {32'h0, 2'b10}) begin errors++; $display("FAIL inj_single got d=%h sec=%b ded=%b want 0/1/0", r_d, r_s, r_e); end
        inj_mask = 39'h3;
        run_word(39'h0, 8'h62, 0, 0);
        checks++; if ({r_s, r_e} !== 2'b01) begin errors++; $display("FAIL inj_double got sec=%b ded=%b want 0/1", r_s, r_e); end
        inj_mask = '0;
    endtask
`endif

    task automatic test_saturation;
        @(negedge clk); cnt_clr = 1;
        @(posedge clk); #1; cnt_clr = 0;
        checks++; if ({s_sec_cnt, sec_cnt} !== {2'd0, 16'd0}) begin errors++; $display("FAIL cnt_clr got %0d/%0d want 0/0", s_sec_cnt, sec_cnt); end
        for (int i = 1; i <= 5; i++) begin
            run_word(39'h20, 8'h70, 0, 0);
            checks++; if (s_sec_cnt !== 2'(i > 3 ? 3 : i)) begin errors++; $display("FAIL sat_%0d got %0d want %0d", i, s_sec_cnt, i > 3 ? 3 : i); end
        end
        checks++; if (sec_cnt !== 16'd5) begin errors++; $display("FAIL wide_cnt got %0d want 5", sec_cnt); end
        run_word(39'h20, 8'h71, 0, 1);
        checks++; if ({s_sec_cnt, sec_cnt} !== {2'd1, 16'd1}) begin errors++; $display("FAIL clr_inc got %0d/%0d want 1/1", s_sec_cnt, sec_cnt); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        in_valid = 1; in_data = 39'h20; in_tag = 8'h77;
        @(posedge clk); #1; in_valid = 0;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        checks++; if ({out_valid, in_ready, out_data, out_tag} !== {1'b0, 1'b1, 32'h0, 8'h0}) begin errors++; $display("FAIL rst_mid got ov=%b rdy=%b d=%h t=%h want 0/1/0/0", out_valid, in_ready, out_data, out_tag); end
        checks++; if ({sec_cnt, log_valid} !== 17'h0) begin errors++; $display("FAIL rst_mid_stats got cnt=%0d log=%b want 0/0", sec_cnt, log_valid); end
        @(negedge clk); rst_n = 1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({out_valid, sec_cnt} !== 17'h0) begin errors++; $display("FAIL rst_drop got ov=%b cnt=%0d want 0/0", out_valid, sec_cnt); end
    endtask

    initial begin
        test_reset;
        test_clean;
        test_sec_data;
        test_parity_double;
        test_other_syndromes;
        test_log;
        test_back_to_back;
`ifdef CBB_ECC_DEC_ERR_INJ_EN
        test_inject;
`endif
        test_saturation;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cbb_ecc_dec_pipe.md
Name: cbb_ecc_dec_pipe

Overview:
- Parametrised, pipelined SECDED decoder with valid/ready flow control, per-word error flags, saturating error counters and a first-error log.
- Sits between memory read ports and consumers; it pairs with the team's SECDED encoder using the same extended-Hamming code.
- Generalises the single-cycle decoder:
  - any DW/EW pair;
  - backpressure;
  - correction of check-bit and overall-parity errors;
  - error statistics for firmware scrubbing.

Parameters:
- DW, 32, data width; 1..247.
- EW, 7, check width including the overall parity bit. Must satisfy 2^(EW-1) >= DW+EW; an elaboration-time $error fires otherwise.
- TW, 8, width of the tag carried with each word (e.g. the read address).
- CW, 16, width of each saturating error counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  decoder accepts a word
- in_data  in  DW+EW  codeword: data in [DW-1:0], Hamming check bits in [DW+:EW-1], overall parity in [DW+EW-1]
- in_tag  in  TW  tag travelling with the word
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  DW  corrected data
- out_tag  out  TW  tag of the result
- out_sec  out  1  single error corrected
- out_ded  out  1  double or uncorrectable error detected
- sec_cnt  out  CW  saturating count of SEC events
- ded_cnt  out  CW  saturating count of DED events
- cnt_clr  in  1  synchronous pulse; clears both counters
- log_valid  out  1  sticky flag: error log holds an entry
- log_tag  out  TW  tag of the first logged error
- log_syn  out  EW-1  syndrome of the first logged error
- log_ded  out  1  type of the first logged error: 1 = DED, 0 = SEC
- log_clr  in  1  synchronous pulse; frees the log

Behaviour:
- Code
  - Data bit i occupies the i-th non-power-of-two Hamming position, counting from 3 (positions 3, 5, 6, 7, 9, ...).
  - Check bit j covers every position whose bit j is set.
  - Overall parity is the XOR of all DW+EW bits and is even for a clean word.
- Pipeline
  - Two stages. S1 registers the syndrome (EW-1 bits), the overall parity, the raw data and the tag. S2 registers the corrected data and the flags.
  - Latency is 2 cycles from an accepted input to out_valid when there is no backpressure.
- Handshake
  - A stage loads when it is empty or its content moves downstream in the same cycle.
  - in_ready = ~s1_valid | s2_load.
  - Transfers occur on valid & ready.
  - Throughput is 1 word/cycle.
  - out_* stay stable while out_valid & ~out_ready.
- Classification, with syn = syndrome and p = overall parity:
  - syn=0, p=0: clean. Data passes through; sec=0, ded=0.
  - syn=0, p=1: error in the parity bit. Data unchanged; sec=1.
  - syn!=0, p=1, and syn names a data position: flip that data bit; sec=1.
  - syn!=0, p=1, and syn is a power of two (check-bit error): data unchanged; sec=1.
  - syn!=0, p=1, and syn is beyond position DW+EW-1 or otherwise unmapped: ded=1.
  - syn!=0, p=0: ded=1.
  - Whenever ded=1, out_data carries the raw, uncorrected data.
- Counters
  - Each counter increments by 1 at the output transfer (out_valid & out_ready) of a word with the corresponding flag.
  - Each counter saturates at 2^CW-1.
  - cnt_clr in the same cycle as an increment leaves the counter at 1.
- Log
  - Captures the first flagged word's tag, syndrome and type at its output transfer, then sets log_valid.
  - Later errors do not overwrite the log while log_valid=1.
  - log_clr in the same cycle as an error capture loads the new entry, so log_valid stays 1.
- Reset, asynchronous:
  - All valids, flags, counters and log fields go to 0.
  - out_data and out_tag go to 0.
  - in_ready goes to 1 after reset.
  - Reset mid-transfer drops all in-flight words.

Optional Feature:
- Macro: CBB_ECC_DEC_ERR_INJ_EN.
- When defined:
  - Adds input port inj_mask [DW+EW-1:0].
  - inj_mask is XORed onto in_data before the syndrome logic, applied to the accepted word only.
  - Lets benches and firmware inject single or double errors.
- When undefined: the port is absent and in_data feeds the decoder directly.

Test Plan (DW=32, EW=7, TW=8, CW=16 unless noted):
- Clean word: in_data=39'h0, tag 8'h11, out_ready=1 → 2 cycles later out_data=0, tag 8'h11, sec=0, ded=0; both counters stay 0.
- Data-bit error: in_data=39'h20 (data bit 5, position 10), tag 8'hA5 → out_data=0, sec=1, sec_cnt=1, log_valid=1, log_syn=6'h0A, log_tag=8'hA5, log_ded=0.
- Parity-bit and double errors:
  - in_data=39'h40_0000_0000 → out_data=0, sec=1.
  - Then in_data=39'h3 → out_data=32'h3, ded=1, ded_cnt=1; the log still holds the earlier SEC entry.
- Backpressure: stream 4 words with out_ready=0 → in_ready drops after 2 words are held. Release out_ready → the 4 words emerge in order with unchanged tags and no loss or duplication.
- Counter saturation, with CW=2: 5 SEC words → sec_cnt sticks at 3. Pulse cnt_clr with a 6th SEC word in the same cycle → sec_cnt=1.
- Injection, macro defined: in_data=0 with inj_mask=39'h1 → sec=1, out_data=0. With inj_mask=39'h3 → ded=1.
